// File: rtl/lsu_rmw_pkg.sv
`default_nettype none
// lsu_rmw_pkg -- funct3 codes, FSM encoding and request-legality helpers for lsu_rmw. Rev 1.0
package lsu_rmw_pkg;

  localparam int XLEN = 32;

  typedef logic [2:0] funct3_t;
  typedef logic [1:0] lane_t;

  localparam funct3_t F3_B  = 3'b000;
  localparam funct3_t F3_H  = 3'b001;
  localparam funct3_t F3_W  = 3'b010;
  localparam funct3_t F3_BU = 3'b100;
  localparam funct3_t F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  function automatic logic f3_legal(input logic store, input funct3_t f3);
    if (store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only meaningful for legal funct3 values.
  function automatic logic is_misaligned(input funct3_t f3, input lane_t lo);
    if (f3[1:0] == 2'b01) begin
      return lo[0];
    end
    if (f3[1:0] == 2'b10) begin
      return lo != 2'b00;
    end
    return 1'b0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_rmw_if.sv
`default_nettype none
// lsu_rmw_if -- request/response and data-memory signals of lsu_rmw. Rev 1.0
interface lsu_rmw_if #(parameter int WIDTH = 32);
  logic             req_valid;
  logic             req_ready;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [WIDTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             resp_valid;
  logic [WIDTH-1:0] resp_rdata;
  logic             resp_err;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             mem_we;
  logic [WIDTH-1:0] mem_rdata;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we
  );
endinterface
`default_nettype wire

// File: rtl/lsu_rmw_align.sv
`default_nettype none
// lsu_rmw_align -- combinational load lane extract/extend and sub-word store merge. Rev 1.0
module lsu_rmw_align
  import lsu_rmw_pkg::*;
(
  input  funct3_t         i_funct3,
  input  lane_t           i_lane,
  input  logic [XLEN-1:0] i_word,
  input  logic [15:0]     i_wdata,
  output logic [XLEN-1:0] o_load,
  output logic [XLEN-1:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[7:0];
    case (i_lane)
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = i_word[7:0];
    endcase
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];
  end

  always_comb begin
    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      default: o_load = i_word;
    endcase
  end

  always_comb begin
    o_merged = i_word;
    if (i_funct3[1:0] == 2'b00) begin
      case (i_lane)
        2'd0:    o_merged[7:0]   = i_wdata[7:0];
        2'd1:    o_merged[15:8]  = i_wdata[7:0];
        2'd2:    o_merged[23:16] = i_wdata[7:0];
        default: o_merged[31:24] = i_wdata[7:0];
      endcase
    end else if (i_funct3[1:0] == 2'b01) begin
      if (i_lane[1]) begin
        o_merged[31:16] = i_wdata;
      end else begin
        o_merged[15:0] = i_wdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lsu_rmw.sv
`default_nettype none
// lsu_rmw -- byte/half/word LSU with read-modify-write for sub-word stores.
// Optional build macro LSU_PERF_CNT_EN adds perf_loads/perf_stores counters. Rev 1.0
module lsu_rmw
  import lsu_rmw_pkg::*;
#(
  parameter int WIDTH           = 32,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  lsu_rmw_if.slave  bus
`ifdef LSU_PERF_CNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores
`endif
);

  logic [1:0]       r_state;
  funct3_t          r_f3;
  lane_t            r_lane;
  logic             r_store;
  logic             r_err;
  logic [15:0]      r_wdata;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;

  logic             w_err;
  lane_t            w_lane;
  logic             w_word_store;
  logic [WIDTH-1:0] w_load;
  logic [WIDTH-1:0] w_merged;

  always_comb begin
    w_err = !f3_legal(bus.req_store, bus.req_funct3) ||
            (ERR_ON_MISALIGN && is_misaligned(bus.req_funct3, bus.req_addr[1:0]));
    // Clearing the low bits is a no-op for aligned requests, so it serves both modes.
    w_lane = bus.req_addr[1:0];
    if (bus.req_funct3[1]) begin
      w_lane = 2'b00;
    end else if (bus.req_funct3[0]) begin
      w_lane[0] = 1'b0;
    end
  end

  assign w_word_store = r_store && (r_f3 == F3_W);

  lsu_rmw_align u_align (
    .i_funct3 (r_f3),
    .i_lane   (r_lane),
    .i_word   (bus.mem_rdata),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_f3        <= F3_B;
      r_lane      <= 2'b00;
      r_store     <= 1'b0;
      r_err       <= 1'b0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_f3    <= bus.req_funct3;
            r_lane  <= w_lane;
            r_store <= bus.req_store;
            r_wdata <= bus.req_wdata[15:0];
            r_err   <= w_err;
            r_rdata <= '0;
            if (w_err) begin
              r_state <= S_RESP;
            end else begin
              r_mem_addr <= {bus.req_addr[WIDTH-1:2], 2'b00};
              if (bus.req_store && (bus.req_funct3 == F3_W)) begin
                r_mem_wdata <= bus.req_wdata;
              end
              r_state <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_store) begin
            r_rdata <= w_load;
            r_state <= S_RESP;
          end else if (w_word_store) begin
            r_state <= S_RESP;
          end else begin
            r_mem_wdata <= w_merged;
            r_state     <= S_WRITE;
          end
        end
        S_WRITE: r_state <= S_RESP;
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef LSU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads  <= '0;
      perf_stores <= '0;
    end else if ((r_state == S_RESP) && !r_err) begin
      if (r_store) begin
        perf_stores <= perf_stores + 32'd1;
      end else begin
        perf_loads <= perf_loads + 32'd1;
      end
    end
  end
`endif

  assign bus.req_ready  = (r_state == S_IDLE);
  assign bus.resp_valid = (r_state == S_RESP);
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wdata  = r_mem_wdata;
  // Gating by rst keeps the reset edge from committing a pending write.
  assign bus.mem_we     = (((r_state == S_ACCESS) && w_word_store) || (r_state == S_WRITE)) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_lsu_rmw.sv
`default_nettype none
// tb_lsu_rmw -- directed plus random self-checking bench against a byte-level memory model.
module tb_lsu_rmw;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_rmw_if bus ();

`ifdef LSU_PERF_CNT_EN
  logic [31:0] perf_loads, perf_stores;
`endif

  lsu_rmw dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef LSU_PERF_CNT_EN
    ,
    .perf_loads  (perf_loads),
    .perf_stores (perf_stores)
`endif
  );

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int total = 0;
  int bad = 0;
  int n_loads = 0;
  int n_stores = 0;

  assign bus.mem_rdata = mem[bus.mem_addr[7:2]];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[7:2]] = v;
    ref_mem[a[7:2]] = v;
  endtask

  // Reference: plain byte-size arithmetic over the word-array model.
  task automatic model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output bit err, output logic [31:0] rd,
                       output int lat, output int wes);
    int size, off, idx;
    bit legal;
    longint unsigned mask, w, v;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    err   = !legal || ((a % size) != 0);
    rd = 0; lat = 1; wes = 0;
    if (!err) begin
      idx  = int'(a[7:2]);
      off  = int'(a[1:0]);
      mask = (64'd1 << (8 * size)) - 1;
      w    = longint'(ref_mem[idx]);
      if (!st) begin
        v = (w >> (8 * off)) & mask;
        if (f3[2] == 1'b0 && size < 4 && ((v >> (8 * size - 1)) & 1) == 1) v = v | (~mask);
        rd = v[31:0];
        lat = 2;
        n_loads++;
      end else begin
        v = (w & ~(mask << (8 * off))) | ((longint'(wd) & mask) << (8 * off));
        ref_mem[idx] = v[31:0];
        lat = (size == 4) ? 2 : 3;
        wes = 1;
        n_stores++;
      end
    end
  endtask

  task automatic do_req(input string tag, input bit st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, output logic [31:0] obs);
    bit exp_err, got;
    logic [31:0] exp_rd, obs_err;
    int exp_lat, exp_wes, lat_obs, wes_obs;
    model(st, f3, a, wd, exp_err, exp_rd, exp_lat, exp_wes);
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_store = st; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk);
    got = 0; lat_obs = 0; wes_obs = 0; obs = 32'hDEADBEEF; obs_err = 32'hDEADBEEF;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      wes_obs += int'(bus.mem_we);
      if (bus.resp_valid) begin
        got = 1; lat_obs = c; obs = bus.resp_rdata; obs_err = {31'd0, bus.resp_err};
      end
    end
    chk({tag, ".lat"}, lat_obs, exp_lat);
    chk({tag, ".rdata"}, obs, exp_rd);
    chk({tag, ".err"}, obs_err, {31'd0, exp_err});
    chk({tag, ".we_cycles"}, wes_obs, exp_wes);
    chk({tag, ".mem"}, mem[a[7:2]], ref_mem[a[7:2]]);
    @(negedge clk);
    chk({tag, ".resp_once"}, {31'd0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = '0; bus.req_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst.rdata", bus.resp_rdata, 32'd0);
    chk("rst.err", {31'd0, bus.resp_err}, 32'd0);
    chk("rst.we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst.addr", bus.mem_addr, 32'd0);
    chk("rst.wdata", bus.mem_wdata, 32'd0);
    rst = 1'b0;

    preload(32'h50, 32'h000000A3);
    do_req("lb50", 1'b0, 3'd0, 32'h50, 32'h0, r);   chk("lb50.lit", r, 32'hFFFFFFA3);
    do_req("lbu50", 1'b0, 3'd4, 32'h50, 32'h0, r);  chk("lbu50.lit", r, 32'h000000A3);
    preload(32'h5C, 32'h00000115);
    do_req("sb5D", 1'b1, 3'd0, 32'h5D, 32'h123456AB, r);
    chk("sb5D.lit", mem[6'h17], 32'h0000AB15);
    preload(32'h54, 32'h00000027);
    do_req("sh56", 1'b1, 3'd1, 32'h56, 32'h00001234, r);
    chk("sh56.lit", mem[6'h15], 32'h12340027);
    do_req("lh56", 1'b0, 3'd1, 32'h56, 32'h0, r);   chk("lh56.lit", r, 32'h00001234);
    preload(32'h58, 32'h0);
    do_req("sh58", 1'b1, 3'd1, 32'h58, 32'hFFFF8000, r);
    do_req("lhu58", 1'b0, 3'd5, 32'h58, 32'h0, r);  chk("lhu58.lit", r, 32'h00008000);
    do_req("lh58", 1'b0, 3'd1, 32'h58, 32'h0, r);   chk("lh58.lit", r, 32'hFFFF8000);
    do_req("lw52", 1'b0, 3'd2, 32'h52, 32'h0, r);
    do_req("sw51", 1'b1, 3'd2, 32'h51, 32'hCAFEF00D, r);
    do_req("ld011", 1'b0, 3'd3, 32'h50, 32'h0, r);
    do_req("st100", 1'b1, 3'd4, 32'h50, 32'h11111111, r);
    do_req("sw54", 1'b1, 3'd2, 32'h54, 32'hA5A55A5A, r);

    for (int i = 0; i < 300; i++) begin
      do_req("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             32'($urandom_range(0, 255)), $urandom, r);
    end

`ifdef LSU_PERF_CNT_EN
    chk("perf_loads", perf_loads, n_loads);
    chk("perf_stores", perf_stores, n_stores);
`endif

    // Reset landing on the WRITE cycle of a sub-word store.
    preload(32'h60, 32'h0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h60; bus.req_wdata = 32'h000000EE;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rstmid.we_before", {31'd0, bus.mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rstmid.we_gated", {31'd0, bus.mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid.mem", mem[6'h18], 32'd0);
    chk("rstmid.ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rstmid.resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rstmid.rdata", bus.resp_rdata, 32'd0);
    chk("rstmid.err", {31'd0, bus.resp_err}, 32'd0);
    chk("rstmid.addr", bus.mem_addr, 32'd0);
    chk("rstmid.wdata", bus.mem_wdata, 32'd0);
`ifdef LSU_PERF_CNT_EN
    chk("rstmid.perf_loads", perf_loads, 32'd0);
    chk("rstmid.perf_stores", perf_stores, 32'd0);
`endif
    do_req("lw60", 1'b0, 3'd2, 32'h60, 32'h0, r);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
